// File: rtl/mac_suma.sv
// mac_suma: sequential signed multiply-accumulate stage.
// Steps a tap index across TAPS sample/coefficient pairs, accumulates one
// full-precision N x N product per cycle into a 2N-bit accumulator, and
// presents the final sum on Suma with a one-cycle active-low Enable strobe.
// Optional feature macro: MAC_SUMA_SATURATE_EN (defined: each accumulate
// step clamps on signed overflow; undefined: plain 2N-bit wrap).
module mac_suma #(
  parameter int N    = 25,
  parameter int TAPS = 5,
  parameter int AW   = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [N-1:0]     X,
  input  logic [N-1:0]     C,
  output logic [AW-1:0]    Addr,
  output logic             Busy,
  output logic [2*N-1:0]   Suma,
  output logic             Enable,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic signed [2*N-1:0] acc_q, acc_d;
  logic signed [2*N-1:0] suma_q, suma_d;
  logic signed [2*N-1:0] product;
  logic signed [2*N-1:0] acc_next;
  logic                  last_tap;

  // Both operands are sign-extended to 2N bits so the product is full precision.
  assign product  = $signed({{N{X[N-1]}}, X}) * $signed({{N{C[N-1]}}, C});
  assign last_tap = (addr_q == AW'(TAPS - 1));

`ifdef MAC_SUMA_SATURATE_EN
  logic signed [2*N-1:0] raw_sum;
  logic                  overflow;

  // Saturating add: equal-sign operands producing an opposite-sign result clamp.
  always_comb begin
    raw_sum  = acc_q + product;
    overflow = (acc_q[2*N-1] == product[2*N-1]) && (raw_sum[2*N-1] != acc_q[2*N-1]);
    acc_next = raw_sum;
    if (overflow) begin
      if (acc_q[2*N-1]) begin
        acc_next = {1'b1, {(2*N-1){1'b0}}};
      end else begin
        acc_next = {1'b0, {(2*N-1){1'b1}}};
      end
    end
  end
`else
  // Plain two's-complement wrap; no overflow detection.
  assign acc_next = acc_q + product;
`endif

  // Next-state, tap index, accumulator and result computation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    acc_d   = acc_q;
    suma_d  = suma_q;
    case (state_q)
      IDLE: begin
        addr_d = '0;
        if (start) begin
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_next;
        if (last_tap) begin
          suma_d  = acc_next;
          addr_d  = '0;
          state_d = DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial sum immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      acc_q   <= '0;
      suma_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      acc_q   <= acc_d;
      suma_q  <= suma_d;
    end
  end

  // Status outputs decode the state register only, so they cannot glitch.
  assign Busy   = (state_q != IDLE);
  assign Enable = (state_q != DONE);
  assign Done   = (state_q == DONE);
  assign Addr   = addr_q;
  assign Suma   = suma_q;

endmodule

// File: tb/tb_mac_suma.sv
// tb_mac_suma: directed self-checking bench for mac_suma (N=25, TAPS=5).
// Honors MAC_SUMA_SATURATE_EN to select overflow expectations.
module tb_mac_suma;

  localparam int N    = 25;
  localparam int TAPS = 5;
  localparam int AW   = 3;

  logic            clk;
  logic            reset_n;
  logic            start;
  logic [N-1:0]    X;
  logic [N-1:0]    C;
  logic [AW-1:0]   Addr;
  logic            Busy;
  logic [2*N-1:0]  Suma;
  logic            Enable;
  logic            Done;

  logic [N-1:0]    xv [8];
  logic [N-1:0]    cv [8];

  int checkCount;
  int passCount;

  mac_suma #(.N(N), .TAPS(TAPS), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .X       (X),
    .C       (C),
    .Addr    (Addr),
    .Busy    (Busy),
    .Suma    (Suma),
    .Enable  (Enable),
    .Done    (Done)
  );

  // Sample/coefficient memories read combinationally at the DUT's tap index.
  assign X = xv[Addr];
  assign C = cv[Addr];

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 200000ns");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic loadUniform(input logic [N-1:0] x, input logic [N-1:0] c);
    for (int i = 0; i < 8; i++) begin
      xv[i] = x;
      cv[i] = c;
    end
  endtask

  // One complete run from IDLE: start in cycle 0, strobe expected in cycle TAPS+1,
  // returns in cycle TAPS+2 (IDLE) so the next run can start immediately.
  // prevSuma must hold on Suma until the new strobe.
  task automatic applyStimulus(input string tag, input logic [2*N-1:0] expSuma,
                               input logic [2*N-1:0] prevSuma);
    int strobes;
    int strobeCycle;
    int doneCount;
    int holdErrors;
    strobes     = 0;
    strobeCycle = -1;
    doneCount   = 0;
    holdErrors  = 0;
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int k = 1; k <= TAPS + 1; k++) begin
      if (k <= TAPS) begin
        checkOutput({tag, "_addr"}, 64'(Addr), 64'(k - 1));
        if (Suma !== prevSuma) holdErrors++;
      end
      if (!Enable) begin
        strobes++;
        strobeCycle = k;
      end
      if (Done) doneCount++;
      if (k == TAPS + 1) begin
        checkOutput({tag, "_suma"}, 64'(Suma), 64'(expSuma));
        checkOutput({tag, "_done_busy"}, 64'({Done, Enable, Busy}), 64'(3'b101));
        checkOutput({tag, "_addr_done"}, 64'(Addr), 64'd0);
      end
      stepCycle();
    end
    checkOutput({tag, "_strobe_count"}, 64'(strobes), 64'd1);
    checkOutput({tag, "_strobe_cycle"}, 64'(strobeCycle), 64'(TAPS + 1));
    checkOutput({tag, "_done_count"}, 64'(doneCount), 64'd1);
    checkOutput({tag, "_suma_hold"}, 64'(holdErrors), 64'd0);
    checkOutput({tag, "_idle_after"}, 64'({Busy, Enable, Done, Suma}), 64'({1'b0, 1'b1, 1'b0, expSuma}));
  endtask

  initial begin
    logic [2*N-1:0] expOvfPos;
    logic [2*N-1:0] expOvfNeg;
    logic [2*N-1:0] lastSuma;
    int strobes;
    int firstStrobe;
    int secondStrobe;

    checkCount = 0;
    passCount  = 0;
    start      = 1'b0;
    loadUniform('0, '0);

`ifdef MAC_SUMA_SATURATE_EN
    expOvfPos = 50'h1_FFFF_FFFF_FFFF;
    expOvfNeg = 50'h1_FFFF_FFFF_FFFF;
`else
    // 5*(2^24-1)^2 mod 2^50 = 2^48 - 5*2^25 + 5
    expOvfPos = 50'h0_FFFF_F600_0005;
    // 5*(2^48) mod 2^50 = 2^48
    expOvfNeg = 50'h1_0000_0000_0000;
`endif

    // Reset values are visible before any clock edge.
    reset_n = 1'b0;
    #2;
    checkOutput("reset_suma", 64'(Suma), 64'd0);
    checkOutput("reset_flags", 64'({Busy, Enable, Done}), 64'(3'b010));
    checkOutput("reset_addr", 64'(Addr), 64'd0);
    stepCycle();
    reset_n = 1'b1;
    stepCycle();

    // Basic sum: X=1, C=1..5 -> 15.
    for (int i = 0; i < TAPS; i++) begin
      xv[i] = 25'd1;
      cv[i] = 25'(i + 1);
    end
    applyStimulus("basic", 50'd15, 50'd0);

    // Signed: X=-3, C=7 -> -105.
    loadUniform(25'h1FF_FFFD, 25'd7);
    applyStimulus("signed", 50'h3_FFFF_FFFF_FF97, 50'd15);

    // Overflow, positive operands.
    loadUniform(25'h0FF_FFFF, 25'h0FF_FFFF);
    applyStimulus("ovf_pos", expOvfPos, 50'h3_FFFF_FFFF_FF97);

    // Overflow, most negative operands.
    loadUniform(25'h100_0000, 25'h100_0000);
    applyStimulus("ovf_neg", expOvfNeg, expOvfPos);

    // Start while busy: pulses in cycles 2 and 6 ignored, cycle 7 starts a new run.
    loadUniform(25'd2, 25'd3);
    strobes      = 0;
    firstStrobe  = -1;
    secondStrobe = -1;
    start = 1'b1;
    stepCycle();
    for (int k = 1; k <= 14; k++) begin
      start = (k == 2 || k == 6 || k == 7);
      if (!Enable) begin
        strobes++;
        if (firstStrobe < 0) firstStrobe = k;
        else secondStrobe = k;
      end
      if (k == 6 || k == 13) checkOutput("busy_start_suma", 64'(Suma), 64'd30);
      stepCycle();
    end
    start = 1'b0;
    checkOutput("busy_start_strobes", 64'(strobes), 64'd2);
    checkOutput("busy_start_first", 64'(firstStrobe), 64'd6);
    checkOutput("busy_start_second", 64'(secondStrobe), 64'd13);
    stepCycle();

    // Reset mid-ACCUM in cycle 3: partial sum discarded, no strobe.
    loadUniform(25'd1, 25'd1);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    stepCycle();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_suma", 64'(Suma), 64'd0);
    checkOutput("midrst_addr", 64'(Addr), 64'd0);
    checkOutput("midrst_flags", 64'({Busy, Enable, Done}), 64'(3'b010));
    stepCycle();
    reset_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      if (!Enable) strobes++;
      stepCycle();
    end
    checkOutput("midrst_no_strobe", 64'(strobes), 64'd0);
    checkOutput("midrst_idle", 64'({Busy, Suma}), 64'd0);

    // Fresh run after reset, then back-to-back runs with differing coefficients.
    for (int i = 0; i < TAPS; i++) begin
      xv[i] = 25'd1;
      cv[i] = 25'(i + 1);
    end
    applyStimulus("b2b_0", 50'd15, 50'd0);
    for (int i = 0; i < TAPS; i++) begin
      xv[i] = 25'd2;
      cv[i] = 25'(TAPS - i);
    end
    applyStimulus("b2b_1", 50'd30, 50'd15);
    for (int i = 0; i < TAPS; i++) begin
      xv[i] = 25'(i + 1);
      cv[i] = 25'(-(i + 1));
    end
    applyStimulus("b2b_2", 50'h3_FFFF_FFFF_FFC9, 50'd30);
    lastSuma = 50'h3_FFFF_FFFF_FFC9;
    loadUniform(25'h1FF_FFFD, 25'd7);
    applyStimulus("b2b_3", 50'h3_FFFF_FFFF_FF97, lastSuma);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
